// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a req/ack data-memory handshake, branch resolution and MEM/WB register.
// Optional sub-word (B/H/BU/HU) load/store support is enabled by defining MEM_SUBWORD_EN.
module mem_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            MemtoReg_i,
  input  logic            RegWrite_i,
  input  logic            Branch_i,
  input  logic            MemWrite_i,
  input  logic            MemRead_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            zero_i,
  input  logic [XLEN-1:0] ALU_result_i,
  input  logic [XLEN-1:0] RTdata_i,
  input  logic [31:0]     instr_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_be_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic            PCSrc_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic            MemtoReg_o,
  output logic            RegWrite_o,
  output logic [XLEN-1:0] mem_data_o,
  output logic [XLEN-1:0] ALU_result_o,
  output logic [RD_W-1:0] rd_o,
  output logic [31:0]     instr_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state;
  logic            access;
  logic            is_read;
  logic [XLEN-1:0] load_data;

  assign access  = MemRead_i | MemWrite_i;
  assign is_read = MemRead_i & ~MemWrite_i;

  // Request is gated by reset so an in-flight access is dropped the moment reset asserts.
  assign dmem_req_o = rst_i & ((state == WAIT) | access);
  assign dmem_we_o  = MemWrite_i;
  assign stall_o    = dmem_req_o & ~dmem_ack_i;

  assign PCSrc_o         = Branch_i & zero_i & ~stall_o;
  assign branch_target_o = pc_i;

`ifdef MEM_SUBWORD_EN
  logic [2:0]  funct3;
  logic [1:0]  byte_off;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign funct3      = instr_i[14:12];
  assign byte_off    = ALU_result_i[1:0];
  assign dmem_addr_o = {ALU_result_i[XLEN-1:2], 2'b00};
  assign sel_byte    = dmem_rdata_i[{byte_off, 3'b000} +: 8];
  assign sel_half    = dmem_rdata_i[{byte_off[1], 4'b0000} +: 16];

  // Stores replicate the narrow datum on every lane; loads pick one lane and extend it.
  always_comb begin
    dmem_be_o    = 4'b1111;
    dmem_wdata_o = RTdata_i;
    load_data    = dmem_rdata_i;
    case (funct3)
      3'b000, 3'b100: begin
        dmem_be_o    = 4'b0001 << byte_off;
        dmem_wdata_o = {(XLEN/8){RTdata_i[7:0]}};
        load_data    = funct3[2] ? {{(XLEN-8){1'b0}}, sel_byte}
                                 : {{(XLEN-8){sel_byte[7]}}, sel_byte};
      end
      3'b001, 3'b101: begin
        dmem_be_o    = 4'b0011 << {byte_off[1], 1'b0};
        dmem_wdata_o = {(XLEN/16){RTdata_i[15:0]}};
        load_data    = funct3[2] ? {{(XLEN-16){1'b0}}, sel_half}
                                 : {{(XLEN-16){sel_half[15]}}, sel_half};
      end
      default: begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = RTdata_i;
        load_data    = dmem_rdata_i;
      end
    endcase
  end
`else
  assign dmem_addr_o  = ALU_result_i;
  assign dmem_be_o    = 4'b1111;
  assign dmem_wdata_o = RTdata_i;
  assign load_data    = dmem_rdata_i;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (access && !dmem_ack_i) state <= WAIT;
        WAIT:    if (dmem_ack_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A stalled cycle pushes a bubble into WB so nothing retires twice.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      MemtoReg_o   <= 1'b0;
      RegWrite_o   <= 1'b0;
      mem_data_o   <= '0;
      ALU_result_o <= '0;
      rd_o         <= '0;
      instr_o      <= '0;
    end else if (stall_o) begin
      MemtoReg_o   <= 1'b0;
      RegWrite_o   <= 1'b0;
      mem_data_o   <= '0;
      ALU_result_o <= '0;
      rd_o         <= '0;
      instr_o      <= '0;
    end else begin
      MemtoReg_o   <= MemtoReg_i;
      RegWrite_o   <= RegWrite_i;
      mem_data_o   <= is_read ? load_data : '0;
      ALU_result_o <= ALU_result_i;
      rd_o         <= instr_i[11:7];
      instr_o      <= instr_i;
    end
  end

endmodule
